// File: rtl/control_unit.sv
// Three-phase (FETCH/DECODE/EXEC) control unit for a simple 64-bit datapath.
// The control word is decoded from IR in DECODE and driven for one cycle in EXEC.
module control_unit #(
  parameter logic [4:0] FS_ADD = 5'b01000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [3:0]  SF,
  output logic        AS,
  output logic [1:0]  DS,
  output logic [1:0]  PS,
  output logic        PC_Sel,
  output logic        K_Sel,
  output logic        IL,
  output logic        SL,
  output logic        MW,
  output logic        RW,
  output logic        C0,
  output logic [4:0]  FS,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [63:0] K,
  output logic [1:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [1:0] S_FETCH  = 2'b00;
  localparam logic [1:0] S_DECODE = 2'b01;
  localparam logic [1:0] S_EXEC   = 2'b10;
  localparam logic [1:0] S_HALT   = 2'b11;

  logic [3:0]  op;
  logic        d_as, d_ksel, d_sl, d_mw, d_rw, d_c0, d_br, d_halt, d_ill;
  logic [1:0]  d_ds, d_ps;
  logic [4:0]  d_fs, d_da, d_sa, d_sb;
  logic [63:0] d_k;
  logic [3:0]  d_cond;

  logic        r_as, r_ksel, r_sl, r_mw, r_rw, r_c0, r_br, r_halt, r_ill;
  logic [1:0]  r_ds, r_ps;
  logic [4:0]  r_fs, r_da, r_sa, r_sb;
  logic [63:0] r_k;
  logic [3:0]  r_cond;
  logic        taken;

  assign op = IR[31:28];

  always_comb begin
    d_as = 1'b0; d_ksel = 1'b0; d_sl = 1'b0; d_mw = 1'b0; d_rw = 1'b0;
    d_c0 = 1'b0; d_br = 1'b0; d_halt = 1'b0; d_ill = 1'b0;
    d_ds = 2'b00; d_ps = 2'b01;
    d_fs = 5'd0; d_da = 5'd0; d_sa = 5'd0; d_sb = 5'd0;
    d_k = 64'd0; d_cond = 4'd0;
    case (op)
      4'h1, 4'h2: begin
        d_fs = IR[26:22];
        d_da = IR[21:17];
        d_sa = IR[16:12];
        d_sb = IR[11:7];
        d_rw = 1'b1;
        d_sl = IR[27];
        d_c0 = (IR[26:22] == 5'b00101);
        if (op == 4'h2) begin
          d_ksel = 1'b1;
          d_k    = {52'd0, IR[11:0]};
        end
      end
      4'h3: begin
        d_fs = FS_ADD; d_sa = IR[16:12]; d_da = IR[21:17];
        d_k = {52'd0, IR[11:0]}; d_ksel = 1'b1;
        d_as = 1'b1; d_ds = 2'b11; d_rw = 1'b1;
      end
      4'h4: begin
        d_fs = FS_ADD; d_sa = IR[16:12]; d_sb = IR[11:7];
        d_k = {52'd0, IR[11:0]}; d_ksel = 1'b1;
        d_as = 1'b1; d_ds = 2'b01; d_mw = 1'b1;
      end
      4'h5: begin
        // Branch outcome is resolved in EXEC against the live flags.
        d_br   = 1'b1;
        d_cond = IR[26:23];
        d_k    = {{41{IR[22]}}, IR[22:0]};
      end
      4'h6: begin
        d_sa = IR[16:12];
        d_ps = 2'b11;
      end
      4'hF: begin
        d_ps   = 2'b00;
        d_halt = 1'b1;
      end
      4'h0: ;
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC:   state <= r_halt ? S_HALT : S_FETCH;
        default:  state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_as <= 1'b0; r_ksel <= 1'b0; r_sl <= 1'b0; r_mw <= 1'b0; r_rw <= 1'b0;
      r_c0 <= 1'b0; r_br <= 1'b0; r_halt <= 1'b0; r_ill <= 1'b0;
      r_ds <= 2'b00; r_ps <= 2'b00;
      r_fs <= 5'd0; r_da <= 5'd0; r_sa <= 5'd0; r_sb <= 5'd0;
      r_k <= 64'd0; r_cond <= 4'd0;
    end else if (state == S_DECODE) begin
      r_as <= d_as; r_ksel <= d_ksel; r_sl <= d_sl; r_mw <= d_mw; r_rw <= d_rw;
      r_c0 <= d_c0; r_br <= d_br; r_halt <= d_halt; r_ill <= d_ill;
      r_ds <= d_ds; r_ps <= d_ps;
      r_fs <= d_fs; r_da <= d_da; r_sa <= d_sa; r_sb <= d_sb;
      r_k <= d_k; r_cond <= d_cond;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retired <= 32'd0;
    else if (state == S_EXEC) retired <= retired + 32'd1;
  end

  always_comb begin
    case (r_cond)
      4'h0:    taken = 1'b1;
      4'h1:    taken = SF[0];
      4'h2:    taken = ~SF[0];
      4'h3:    taken = SF[1];
      4'h4:    taken = ~SF[1];
      4'h5:    taken = SF[2];
      4'h6:    taken = SF[3];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    AS = 1'b0; DS = 2'b00; PS = 2'b00; PC_Sel = 1'b0; K_Sel = 1'b0;
    IL = 1'b0; SL = 1'b0; MW = 1'b0; RW = 1'b0; C0 = 1'b0;
    FS = 5'd0; DA = 5'd0; SA = 5'd0; SB = 5'd0; K = 64'd0; illegal = 1'b0;
    case (state)
      S_FETCH: begin
        IL = 1'b1;
        DS = 2'b11;
      end
      S_EXEC: begin
        AS = r_as; DS = r_ds; K_Sel = r_ksel; SL = r_sl; MW = r_mw; RW = r_rw;
        C0 = r_c0; FS = r_fs; DA = r_da; SA = r_sa; SB = r_sb; illegal = r_ill;
        if (r_br) begin
          PS     = taken ? 2'b10 : 2'b01;
          PC_Sel = taken;
          K      = taken ? r_k : 64'd0;
        end else begin
          PS = r_ps;
          K  = r_k;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, random
// instructions against a field-level reference model, and reset/HALT sequences.
module tb_control_unit;

  typedef struct packed {
    logic        as_sel;
    logic [1:0]  ds;
    logic [1:0]  ps;
    logic        pc_sel;
    logic        k_sel;
    logic        il;
    logic        sl;
    logic        mw;
    logic        rw;
    logic        c0;
    logic [4:0]  fs;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [63:0] k;
    logic        ill;
  } ctl_t;

  localparam int CW = $bits(ctl_t);
  localparam logic [4:0] FS_ADD = 5'b01000;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  sf;
    ctl_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IR = 32'd0;
  logic [3:0]  SF = 4'd0;
  logic        AS, PC_Sel, K_Sel, IL, SL, MW, RW, C0, illegal;
  logic [1:0]  DS, PS, state;
  logic [4:0]  FS, DA, SA, SB;
  logic [63:0] K;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ret_exp = 32'd0;
  logic [CW-1:0] exp_q[$];
  vec_t vt[10];

  control_unit #(.FS_ADD(FS_ADD)) dut (
    .clk(clk), .rst(rst), .IR(IR), .SF(SF),
    .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel),
    .IL(IL), .SL(SL), .MW(MW), .RW(RW), .C0(C0),
    .FS(FS), .DA(DA), .SA(SA), .SB(SB), .K(K),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic ctl_t c(input logic as_sel, input logic [1:0] ds, input logic [1:0] ps,
                             input logic pc_sel, input logic k_sel, input logic sl,
                             input logic mw, input logic rw, input logic c0,
                             input logic [4:0] fs, input logic [4:0] da,
                             input logic [4:0] sa, input logic [4:0] sb,
                             input logic [63:0] k, input logic ill);
    ctl_t r;
    r = '0;
    r.as_sel = as_sel; r.ds = ds; r.ps = ps; r.pc_sel = pc_sel; r.k_sel = k_sel;
    r.sl = sl; r.mw = mw; r.rw = rw; r.c0 = c0; r.fs = fs; r.da = da;
    r.sa = sa; r.sb = sb; r.k = k; r.ill = ill;
    return r;
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t r;
    r = '0;
    r.il = 1'b1;
    r.ds = 2'b11;
    return r;
  endfunction

  function automatic ctl_t get_ctl();
    ctl_t r;
    r.as_sel = AS; r.ds = DS; r.ps = PS; r.pc_sel = PC_Sel; r.k_sel = K_Sel;
    r.il = IL; r.sl = SL; r.mw = MW; r.rw = RW; r.c0 = C0; r.fs = FS;
    r.da = DA; r.sa = SA; r.sb = SB; r.k = K; r.ill = illegal;
    return r;
  endfunction

  // Reference: EXEC-cycle control word straight from the instruction field rules.
  function automatic ctl_t model(input logic [31:0] ir, input logic [3:0] sf);
    ctl_t r;
    logic [3:0]  op;
    logic        z, n, cy, v, tk;
    logic [63:0] imm, off;
    op  = ir[31:28];
    imm = 64'(ir[11:0]);
    off = 64'($signed(ir[22:0]));
    {v, cy, n, z} = sf;
    r = '0;
    r.ps = 2'b01;
    if (op == 4'h1 || op == 4'h2) begin
      r.fs = ir[26:22]; r.da = ir[21:17]; r.sa = ir[16:12]; r.sb = ir[11:7];
      r.rw = 1'b1; r.sl = ir[27]; r.c0 = (ir[26:22] == 5'd5);
      if (op == 4'h2) begin r.k_sel = 1'b1; r.k = imm; end
    end else if (op == 4'h3) begin
      r.fs = FS_ADD; r.sa = ir[16:12]; r.da = ir[21:17]; r.k = imm;
      r.k_sel = 1'b1; r.as_sel = 1'b1; r.ds = 2'b11; r.rw = 1'b1;
    end else if (op == 4'h4) begin
      r.fs = FS_ADD; r.sa = ir[16:12]; r.sb = ir[11:7]; r.k = imm;
      r.k_sel = 1'b1; r.as_sel = 1'b1; r.ds = 2'b01; r.mw = 1'b1;
    end else if (op == 4'h5) begin
      tk = (ir[26:23] == 4'd0) || (ir[26:23] == 4'd1 && z) || (ir[26:23] == 4'd2 && !z) ||
           (ir[26:23] == 4'd3 && n) || (ir[26:23] == 4'd4 && !n) ||
           (ir[26:23] == 4'd5 && cy) || (ir[26:23] == 4'd6 && v);
      if (tk) begin r.pc_sel = 1'b1; r.k = off; r.ps = 2'b10; end
    end else if (op == 4'h6) begin
      r.sa = ir[16:12]; r.ps = 2'b11;
    end else if (op == 4'hF) begin
      r.ps = 2'b00;
    end else if (op != 4'h0) begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a falling edge with the DUT in FETCH; ends the same way
  // (or in HALT when the instruction was HALT).
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] sf, input ctl_t exp,
                           input bit halts, input string tag);
    logic [CW-1:0] e;
    IR = ir;
    SF = sf;
    exp_q.push_back(exp);
    #1;
    chk({tag, " fetch_state"}, 128'(state), 128'(2'b00));
    chk({tag, " fetch_ctl"}, 128'(get_ctl()), 128'(fetch_ctl()));
    @(negedge clk);
    chk({tag, " decode_state"}, 128'(state), 128'(2'b01));
    chk({tag, " decode_ctl"}, 128'(get_ctl()), 128'(0));
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, " exec_state"}, 128'(state), 128'(2'b10));
    chk({tag, " exec_ctl"}, 128'(get_ctl()), 128'(e));
    @(negedge clk);
    ret_exp = ret_exp + 32'd1;
    chk({tag, " retired"}, 128'(retired), 128'(ret_exp));
    chk({tag, " next_state"}, 128'(state), halts ? 128'(2'b11) : 128'(2'b00));
  endtask

  initial begin
    logic [31:0] rir;
    logic [3:0]  rsf;

    vt[0] = '{32'h1C06_2180, 4'h0, c(0, 2'b00, 2'b01, 0, 0, 1, 0, 1, 0, 5'b10000, 5'd3, 5'd2, 5'd3, 64'd0, 0)};
    vt[1] = '{32'h3008_1010, 4'h0, c(1, 2'b11, 2'b01, 0, 1, 0, 0, 1, 0, FS_ADD, 5'd4, 5'd1, 5'd0, 64'h10, 0)};
    vt[2] = '{32'h50FF_FFFC, 4'h1, c(0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0)};
    vt[3] = '{32'h50FF_FFFC, 4'h0, c(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0)};
    vt[4] = '{32'h9000_0000, 4'h0, c(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1)};
    vt[5] = '{32'h0000_0000, 4'h5, c(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0)};
    vt[6] = '{32'h2142_20AB, 4'h0, c(0, 2'b00, 2'b01, 0, 1, 0, 0, 1, 1, 5'd5, 5'd1, 5'd2, 5'd1, 64'hAB, 0)};
    vt[7] = '{32'h4000_3185, 4'h0, c(1, 2'b01, 2'b01, 0, 1, 0, 1, 0, 0, FS_ADD, 5'd0, 5'd3, 5'd3, 64'h185, 0)};
    vt[8] = '{32'h6000_7000, 4'h0, c(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd7, 5'd0, 64'd0, 0)};
    vt[9] = '{32'h5380_0004, 4'hF, c(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0)};

    #2;
    chk("reset_state", 128'(state), 128'(2'b00));
    chk("reset_ctl", 128'(get_ctl()), 128'(fetch_ctl()));
    chk("reset_retired", 128'(retired), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_instr(vt[i].ir, vt[i].sf, vt[i].exp, 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rir = {4'($urandom_range(0, 14)), 28'($urandom)};
      rsf = 4'($urandom_range(0, 15));
      run_instr(rir, rsf, model(rir, rsf), 1'b0, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of an ST's EXEC cycle.
    IR = 32'h4000_3185;
    @(negedge clk);
    @(negedge clk);
    chk("st_exec_mw", 128'(MW), 128'(1));
    #1 rst = 1'b1;
    #1;
    chk("st_abort_mw", 128'(MW), 128'(0));
    chk("st_abort_state", 128'(state), 128'(2'b00));
    chk("st_abort_ctl", 128'(get_ctl()), 128'(fetch_ctl()));
    chk("st_abort_retired", 128'(retired), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    ret_exp = 32'd0;

    run_instr(32'h1C06_2180, 4'h0, model(32'h1C06_2180, 4'h0), 1'b0, "post_abort");
    run_instr(32'hF000_0000, 4'h0, model(32'hF000_0000, 4'h0), 1'b1, "halt");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("halt_state%0d", i), 128'(state), 128'(2'b11));
      chk($sformatf("halt_ctl%0d", i), 128'(get_ctl()), 128'(0));
      chk($sformatf("halt_retired%0d", i), 128'(retired), 128'(ret_exp));
    end
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_state", 128'(state), 128'(2'b00));
    chk("halt_rst_retired", 128'(retired), 128'(0));
    chk("halt_rst_ctl", 128'(get_ctl()), 128'(fetch_ctl()));
    @(negedge clk);
    rst = 1'b0;
    ret_exp = 32'd0;
    run_instr(32'h9000_0000, 4'h0, model(32'h9000_0000, 4'h0), 1'b0, "post_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
